// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the video PLL dynamic configuration controller.
package pll_cfg_pkg;

    // Controller sequence states.
    typedef enum logic [2:0] {
        RST       = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        LOCKED    = 3'd3,
        ERROR     = 3'd4
    } pll_state_e;

    // Divider/duty values driven out of reset.
    localparam int ODIV_DEFAULT = 100;
    localparam int DUTY_DEFAULT = 100;

    // Default timing limits.
    localparam int LOCK_TIMEOUT_DEFAULT  = 65535;
    localparam int STABLE_CYCLES_DEFAULT = 256;

    // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int TMR_W_DEFAULT = cnt_w(LOCK_TIMEOUT_DEFAULT);
    localparam int STB_W_DEFAULT = cnt_w(STABLE_CYCLES_DEFAULT);

endpackage

// File: rtl/pll_dyn_cfg_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchroniser; both flops clear to 0 on rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic meta_p1;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            meta_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            meta_p1 <= meta_p0;
        end
    end

    assign q = meta_p1;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Video PLL reset and dynamic divider/duty controller.
// Sequences power-up and reconfiguration: hold pll_rst, release, wait for a
// synchronised lock, qualify it for STABLE_CYCLES, then report LOCKED.
// Optional build macro LOCK_LOSS_RECOVER_EN: a lock drop while LOCKED
// triggers an automatic reset/re-lock sequence instead of just clearing locked.
module pll_dyn_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int DIV_W         = 10,
    parameter int ODIV_DEF      = ODIV_DEFAULT,
    parameter int DUTY_DEF      = DUTY_DEFAULT,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_odiv,
    input  logic [DIV_W-1:0] cfg_duty,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic [DIV_W-1:0] dyn_odiv,
    output logic [DIV_W-1:0] dyn_duty,
    output logic             locked,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [1:0]       retry_cnt
);

    localparam logic [2:0] S_RST       = RST;
    localparam logic [2:0] S_WAIT_LOCK = WAIT_LOCK;
    localparam logic [2:0] S_STABLE    = STABLE;
    localparam logic [2:0] S_LOCKED    = LOCKED;
    localparam logic [2:0] S_ERROR     = ERROR;

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int TMR_W = cnt_w(LOCK_TIMEOUT);
    localparam int STB_W = cnt_w(STABLE_CYCLES);

    logic             lock_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic [TMR_W-1:0] tmr;
    logic [STB_W-1:0] stb_cnt;
    logic             accept;
    logic             cfg_bad;
    logic             tmo;
    logic             keep_tmr;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign cfg_ready = (state == S_LOCKED) || (state == S_ERROR);
    assign accept    = cfg_valid & cfg_ready;
    assign cfg_bad   = (cfg_odiv == '0) || (cfg_duty == '0);
    assign tmo       = (tmr >= TMR_W'(LOCK_TIMEOUT));
    // The lock timeout measures time since pll_rst release, so bouncing
    // between WAIT_LOCK and STABLE must not restart it.
    assign keep_tmr  = ((state == S_WAIT_LOCK) && (state_nxt == S_STABLE)) ||
                       ((state == S_STABLE) && (state_nxt == S_WAIT_LOCK));

    // Next-state decode for the bring-up / reconfiguration sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST: begin
                if (rst_cnt >= RST_W'(RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s)   state_nxt = S_STABLE;
                else if (tmo) state_nxt = (retry_cnt < 2'(MAX_RETRY)) ? S_RST : S_ERROR;
            end
            S_STABLE: begin
                if (!lock_s) state_nxt = S_WAIT_LOCK;
                else if (stb_cnt >= STB_W'(STABLE_CYCLES - 1)) state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                if (accept && !cfg_bad) state_nxt = S_RST;
`ifdef LOCK_LOSS_RECOVER_EN
                else if (!lock_s) state_nxt = S_RST;
`endif
            end
            S_ERROR: begin
                if (accept && !cfg_bad) state_nxt = S_RST;
            end
            default: state_nxt = S_RST;
        endcase
    end

    // State register and saturating sequence counters, cleared on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            rst_cnt <= '0;
            tmr     <= '0;
            stb_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                rst_cnt <= '0;
                stb_cnt <= '0;
                if (!keep_tmr)  tmr <= '0;
                else if (!tmo)  tmr <= tmr + 1'b1;
            end else begin
                if (rst_cnt < RST_W'(RST_CYCLES))    rst_cnt <= rst_cnt + 1'b1;
                if (stb_cnt < STB_W'(STABLE_CYCLES)) stb_cnt <= stb_cnt + 1'b1;
                if (!tmo)                            tmr     <= tmr + 1'b1;
            end
        end
    end

    // Registered PLL-facing outputs and status; dyn_* only move on the edge
    // that also raises pll_rst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            dyn_odiv  <= DIV_W'(ODIV_DEF);
            dyn_duty  <= DIV_W'(DUTY_DEF);
            locked    <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            retry_cnt <= 2'd0;
        end else begin
            pll_rst  <= (state_nxt == S_RST) || (state_nxt == S_ERROR);
            cfg_done <= (state_nxt == S_LOCKED) && (state != S_LOCKED);
            locked   <= (state_nxt == S_LOCKED) && lock_s;
            if (accept) begin
                if (cfg_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    dyn_odiv  <= cfg_odiv;
                    dyn_duty  <= cfg_duty;
                    cfg_err   <= 1'b0;
                    retry_cnt <= 2'd0;
                end
            end else if ((state == S_WAIT_LOCK) && !lock_s && tmo) begin
                if (retry_cnt < 2'(MAX_RETRY)) retry_cnt <= retry_cnt + 2'd1;
                else                           cfg_err   <= 1'b1;
            end else if ((state == S_LOCKED) && (state_nxt == S_RST)) begin
                retry_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Scoreboard bench for pll_dyn_cfg_ctrl: a simple PLL model, randomized
// requests, expected events queued by the stimulus and popped by a monitor.
module tb_pll_dyn_cfg_ctrl;

    localparam int DIV_W         = 10;
    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 1000;
    localparam int STABLE_CYCLES = 256;
    localparam int MAX_RETRY     = 3;
    localparam int ODIV_DEF      = 100;
    localparam int DUTY_DEF      = 100;

    localparam int EV_FALL = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int odiv;
        int duty;
        int retry;
        int chk_w;
        int dly;
        int rst_exp;
    } ev_t;

    logic             clk_tb;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_odiv;
    logic [DIV_W-1:0] cfg_duty;
    logic             pll_lock;
    logic             pll_rst;
    logic [DIV_W-1:0] dyn_odiv;
    logic [DIV_W-1:0] dyn_duty;
    logic             locked;
    logic             cfg_done;
    logic             cfg_err;
    logic [1:0]       retry_cnt;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t exp_q[$];

    // PLL model knobs
    int  lock_delay = 500;
    int  glitch_at  = 0;
    bit  never_lock = 0;
    bit  drop_low   = 0;
    int  pll_cnt    = 0;

    int  cur_odiv = ODIV_DEF;
    int  cur_duty = DUTY_DEF;

    pll_dyn_cfg_ctrl #(
        .DIV_W         (DIV_W),
        .ODIV_DEF      (ODIV_DEF),
        .DUTY_DEF      (DUTY_DEF),
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_odiv  (cfg_odiv),
        .cfg_duty  (cfg_duty),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .dyn_odiv  (dyn_odiv),
        .dyn_duty  (dyn_duty),
        .locked    (locked),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .retry_cnt (retry_cnt)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    always @(posedge clk_tb) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int od, input int du, input int rt,
                           input int chk_w, input int dly, input int rst_exp);
        ev_t e;
        e.kind = kind; e.odiv = od; e.duty = du; e.retry = rt;
        e.chk_w = chk_w; e.dly = dly; e.rst_exp = rst_exp;
        exp_q.push_back(e);
    endtask

    // PLL model: lock asserts lock_delay cycles after pll_rst is released;
    // optional one-cycle glitch glitch_at cycles after lock, forced drop window.
    always @(negedge clk_tb) begin
        if (pll_rst || never_lock) begin
            pll_cnt  = 0;
            pll_lock = 1'b0;
        end else begin
            if (pll_cnt < 1_000_000) pll_cnt++;
            pll_lock = (pll_cnt >= lock_delay) && !drop_low &&
                       !((glitch_at > 0) && (pll_cnt == lock_delay + glitch_at));
        end
    end

    // Monitor: detects DUT events and compares them with the queued expectations.
    bit prev_rst  = 1'b1;
    bit prev_err  = 1'b0;
    bit rise_seen = 1'b0;
    int rise_cyc  = 0;
    int fall_cyc  = 0;

    task automatic pop_expect(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (exp_q.size() == 0) begin
            check("event_queue_nonempty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    always @(negedge clk_tb) begin
        ev_t e;
        bit  ok;
        if (!rst_n) begin
            prev_rst  = 1'b1;
            prev_err  = 1'b0;
            rise_seen = 1'b0;
        end else begin
            if (pll_rst && !prev_rst) begin
                rise_seen = 1'b1;
                rise_cyc  = cyc;
            end
            if (!pll_rst && prev_rst) begin
                pop_expect(EV_FALL, e, ok);
                if (ok) begin
                    if (e.chk_w != 0 && rise_seen) check("rst_width", cyc - rise_cyc, RST_CYCLES);
                    check("fall_odiv", int'(dyn_odiv), e.odiv);
                    check("fall_duty", int'(dyn_duty), e.duty);
                    check("fall_retry", int'(retry_cnt), e.retry);
                end
                fall_cyc  = cyc;
                rise_seen = 1'b0;
            end
            if (cfg_done) begin
                pop_expect(EV_DONE, e, ok);
                if (ok) begin
                    check("done_delay", cyc - fall_cyc, e.dly);
                    check("done_odiv", int'(dyn_odiv), e.odiv);
                    check("done_duty", int'(dyn_duty), e.duty);
                    check("done_retry", int'(retry_cnt), 0);
                    check("done_locked", int'(locked), 1);
                end
            end
            if (cfg_err && !prev_err) begin
                pop_expect(EV_ERR, e, ok);
                if (ok) begin
                    check("err_retry", int'(retry_cnt), e.retry);
                    check("err_pll_rst", int'(pll_rst), e.rst_exp);
                    check("err_odiv", int'(dyn_odiv), e.odiv);
                end
            end
            prev_rst = pll_rst;
            prev_err = cfg_err;
        end
    end

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_tb);
            n++;
        end
        check({nm, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_cfg(input int od, input int du);
        int n;
        n = 0;
        @(negedge clk_tb);
        while (!cfg_ready && n < 5000) begin
            @(negedge clk_tb);
            n++;
        end
        check("ready_before_send", int'(cfg_ready), 1);
        cfg_odiv  = DIV_W'(od);
        cfg_duty  = DIV_W'(du);
        cfg_valid = 1'b1;
        @(posedge clk_tb);
        #1;
        cfg_valid = 1'b0;
        if (od != 0 && du != 0) begin
            check("acc_pll_rst", int'(pll_rst), 1);
            check("acc_odiv", int'(dyn_odiv), od);
            check("acc_duty", int'(dyn_duty), du);
            check("acc_err_clr", int'(cfg_err), 0);
            check("acc_ready_low", int'(cfg_ready), 0);
            cur_odiv = od;
            cur_duty = du;
        end else begin
            check("bad_err", int'(cfg_err), 1);
            check("bad_odiv_kept", int'(dyn_odiv), cur_odiv);
            check("bad_ready_kept", int'(cfg_ready), 1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_dyn_odiv"}, int'(dyn_odiv), ODIV_DEF);
        check({tag, "_dyn_duty"}, int'(dyn_duty), DUTY_DEF);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_cfg_done"}, int'(cfg_done), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
        check({tag, "_retry"}, int'(retry_cnt), 0);
        check({tag, "_ready"}, int'(cfg_ready), 0);
    endtask

    // Expected cfg_done delay after pll_rst falls: lock needs d cycles, then
    // 2 sync flops, one decision edge into qualification, STABLE_CYCLES clean
    // samples. A one-cycle glitch g cycles after lock restarts qualification
    // from the sample after the glitch, adding g+1 cycles.
    function automatic int done_dly(input int d, input int g);
        return d + 2 + STABLE_CYCLES + ((g > 0) ? g + 1 : 0);
    endfunction

    initial begin
        int od;
        int du;
        int d;
        int g;
        int rst_hi;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_odiv  = '0;
        cfg_duty  = '0;
        pll_lock  = 1'b0;

        // Power-up with default dividers, lock after 500 cycles
        repeat (3) @(posedge clk_tb);
        #1;
        check_reset_vals("por");
        lock_delay = 500;
        push_ev(EV_FALL, ODIV_DEF, DUTY_DEF, 0, 0, 0, 0);
        push_ev(EV_DONE, ODIV_DEF, DUTY_DEF, 0, 0, done_dly(500, 0), 0);
        @(negedge clk_tb);
        rst_n = 1'b1;
        wait_drain("powerup", 3000);
        check("powerup_ready", int'(cfg_ready), 1);

        // Reconfiguration, first one fixed at 200/200
        for (int i = 0; i < 3; i++) begin
            od = (i == 0) ? 200 : int'($urandom_range(1, 1023));
            du = (i == 0) ? 200 : int'($urandom_range(1, 1023));
            d  = int'($urandom_range(20, 600));
            lock_delay = d;
            push_ev(EV_FALL, od, du, 0, 1, 0, 0);
            push_ev(EV_DONE, od, du, 0, 0, done_dly(d, 0), 0);
            send_cfg(od, du);
            wait_drain("reconfig", 3000);
        end

        // One-cycle lock glitch during qualification
        for (int i = 0; i < 2; i++) begin
            g  = (i == 0) ? 100 : int'($urandom_range(1, 200));
            d  = int'($urandom_range(20, 400));
            od = int'($urandom_range(1, 1023));
            du = int'($urandom_range(1, 1023));
            lock_delay = d;
            glitch_at  = g;
            push_ev(EV_FALL, od, du, 0, 1, 0, 0);
            push_ev(EV_DONE, od, du, 0, 0, done_dly(d, g), 0);
            send_cfg(od, du);
            wait_drain("glitch", 3000);
            glitch_at = 0;
        end

        // Zero divider/duty: accepted, flagged, no sequence restart
        push_ev(EV_ERR, cur_odiv, cur_duty, 0, 0, 0, 0);
        send_cfg(0, int'($urandom_range(1, 1023)));
        wait_drain("bad_cfg", 20);
        send_cfg(int'($urandom_range(1, 1023)), 0);
        check("bad_locked_kept", int'(locked), 1);
        od = int'($urandom_range(1, 1023));
        du = int'($urandom_range(1, 1023));
        d  = int'($urandom_range(20, 600));
        lock_delay = d;
        push_ev(EV_FALL, od, du, 0, 1, 0, 0);
        push_ev(EV_DONE, od, du, 0, 0, done_dly(d, 0), 0);
        send_cfg(od, du);
        wait_drain("after_bad", 3000);

        // Lock loss while LOCKED
`ifdef LOCK_LOSS_RECOVER_EN
        d = int'($urandom_range(60, 300));
        lock_delay = d;
        push_ev(EV_FALL, cur_odiv, cur_duty, 0, 1, 0, 0);
        push_ev(EV_DONE, cur_odiv, cur_duty, 0, 0, done_dly(d, 0), 0);
        @(negedge clk_tb);
        drop_low = 1'b1;
        repeat (10) @(negedge clk_tb);
        check("loss_locked_low", int'(locked), 0);
        repeat (40) @(negedge clk_tb);
        drop_low = 1'b0;
        wait_drain("loss_recover", 3000);
`else
        rst_hi = 0;
        @(negedge clk_tb);
        drop_low = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_tb);
            if (pll_rst) rst_hi = 1;
            if (i == 10) begin
                check("loss_locked_low", int'(locked), 0);
                check("loss_ready_high", int'(cfg_ready), 1);
            end
        end
        drop_low = 1'b0;
        repeat (6) @(negedge clk_tb);
        if (pll_rst) rst_hi = 1;
        check("loss_no_pll_rst", rst_hi, 0);
        check("loss_locked_back", int'(locked), 1);
`endif

        // PLL never locks: 4 reset attempts, then ERROR with pll_rst held
        never_lock = 1'b1;
        od = int'($urandom_range(1, 1023));
        du = int'($urandom_range(1, 1023));
        for (int r = 0; r <= MAX_RETRY; r++) push_ev(EV_FALL, od, du, r, 1, 0, 0);
        push_ev(EV_ERR, od, du, MAX_RETRY, 0, 0, 1);
        send_cfg(od, du);
        wait_drain("timeout", 6000);
        repeat (5) @(negedge clk_tb);
        check("err_rst_held", int'(pll_rst), 1);
        check("err_flag_held", int'(cfg_err), 1);
        check("err_ready", int'(cfg_ready), 1);
        never_lock = 1'b0;
        od = int'($urandom_range(1, 1023));
        du = int'($urandom_range(1, 1023));
        d  = int'($urandom_range(20, 600));
        lock_delay = d;
        push_ev(EV_FALL, od, du, 0, 0, 0, 0);
        push_ev(EV_DONE, od, du, 0, 0, done_dly(d, 0), 0);
        send_cfg(od, du);
        wait_drain("err_recover", 3000);

        // Asynchronous reset while waiting for lock with dyn_odiv=200
        lock_delay = 800;
        push_ev(EV_FALL, 200, 200, 0, 1, 0, 0);
        send_cfg(200, 200);
        wait_drain("pre_midrst", 100);
        repeat (10) @(negedge clk_tb);
        check("midrst_pre_odiv", int'(dyn_odiv), 200);
        @(posedge clk_tb);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        cur_odiv = ODIV_DEF;
        cur_duty = DUTY_DEF;
        repeat (3) @(negedge clk_tb);
        lock_delay = 300;
        push_ev(EV_FALL, ODIV_DEF, DUTY_DEF, 0, 0, 0, 0);
        push_ev(EV_DONE, ODIV_DEF, DUTY_DEF, 0, 0, done_dly(300, 0), 0);
        rst_n = 1'b1;
        wait_drain("post_midrst", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
